// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: D = A - B - Bin one nibble per clock, LSB first; SIGNED_OVF_EN adds overflow flag V
module nibble_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SIGNED_OVF_EN
    ,
    output logic             V
`endif
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, d_nxt;
    logic             borrow_reg;
    logic [CW-1:0]    cnt;
    logic [4:0]       sub;
    logic             last;
`ifdef SIGNED_OVF_EN
    logic             a_msb, b_msb;
`endif

    assign sub       = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0, borrow_reg};
    assign last      = cnt == CW'(NIBBLES - 1);
    assign d_nxt     = (D >> 4) | (WIDTH'(sub[3:0]) << (WIDTH - 4));
    assign IN_READY  = state == IDLE;
    assign OUT_VALID = state == DONE;

    // accept in IDLE, finish after the last nibble, release when the result is consumed
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE && IN_VALID)  ? RUN  :
                    (state == RUN  && last)      ? DONE :
                    (state == DONE && OUT_READY) ? IDLE : state;
    end

    // state register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else state <= state_nxt;
    end

    // operand capture, per-nibble subtract with registered borrow, result shift-in from the MSB end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_sh       <= '0;
            b_sh       <= '0;
            borrow_reg <= 1'b0;
            cnt        <= '0;
            D          <= '0;
            Bout       <= 1'b0;
`ifdef SIGNED_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            V          <= 1'b0;
`endif
        end else if (state == IDLE && IN_VALID) begin
            a_sh       <= A;
            b_sh       <= B;
            borrow_reg <= Bin;
            cnt        <= '0;
`ifdef SIGNED_OVF_EN
            a_msb      <= A[WIDTH-1];
            b_msb      <= B[WIDTH-1];
`endif
        end else if (state == RUN) begin
            a_sh       <= a_sh >> 4;
            b_sh       <= b_sh >> 4;
            borrow_reg <= sub[4];
            cnt        <= cnt + 1'b1;
            D          <= d_nxt;
            if (last) Bout <= sub[4];
`ifdef SIGNED_OVF_EN
            if (last) V <= (a_msb != b_msb) && (sub[3] != a_msb);
`endif
        end
    end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: randomized and directed checks against an arithmetic reference model
module tb_nibble_serial_subtractor;
    localparam int WIDTH = 8;
    localparam int NIBBLES = WIDTH / 4;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Bin = 1'b0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SIGNED_OVF_EN
    logic             V;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] nxt_a, nxt_b;
    logic             nxt_bin;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .Bin(Bin), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .D(D), .Bout(Bout)
`ifdef SIGNED_OVF_EN
        , .V(V)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; leaves the bench at a negedge with the block back in IDLE
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         input int hold, input bit keep_valid, input bit chk_v, input logic exp_v);
        int exp_d;
        logic exp_bout;
        exp_d = (int'(a) - int'(b) - int'(bin)) & ((1 << WIDTH) - 1);
        exp_bout = int'(a) < int'(b) + int'(bin);
        A = a; B = b; Bin = bin; IN_VALID = 1'b1;
        check("in_ready_idle", IN_READY, 1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        A = $urandom; B = $urandom; Bin = 1'($urandom);
        check("out_valid_accept", OUT_VALID, 0);
        check("in_ready_run", IN_READY, 0);
        for (int k = 1; k <= NIBBLES; k++) begin
            @(negedge CLK);
            check("out_valid_latency", OUT_VALID, k == NIBBLES);
        end
        check("d", D, exp_d);
        check("bout", Bout, exp_bout);
        check("in_ready_done", IN_READY, 0);
`ifdef SIGNED_OVF_EN
        if (chk_v) check("v", V, exp_v);
`endif
        for (int i = 0; i < hold; i++) begin
            nxt_a = $urandom; nxt_b = $urandom; nxt_bin = 1'($urandom);
            A = nxt_a; B = nxt_b; Bin = nxt_bin; IN_VALID = 1'b1;
            @(negedge CLK);
            check("hold_valid", OUT_VALID, 1);
            check("hold_ready", IN_READY, 0);
            check("hold_d", D, exp_d);
            check("hold_bout", Bout, exp_bout);
        end
        IN_VALID = keep_valid;
        OUT_READY = 1'b1;
        @(negedge CLK);
        OUT_READY = 1'b0;
        check("release_valid", OUT_VALID, 0);
        check("release_ready", IN_READY, 1);
        check("release_d_kept", D, exp_d);
        if (!keep_valid) begin
            A = $urandom; B = $urandom;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rbin;
        IN_VALID = 1'b1; A = 8'h11; B = 8'h22;
        repeat (2) @(negedge CLK);
        check("rst_valid", OUT_VALID, 0);
        check("rst_ready", IN_READY, 1);
        check("rst_d", D, 0);
        check("rst_bout", Bout, 0);
        IN_VALID = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        check("idle_no_accept", IN_READY, 1);

        do_op(8'h5A, 8'h23, 1'b0, 0, 0, 0, 1'b0);
        do_op(8'h10, 8'h01, 1'b0, 0, 0, 0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 0, 0, 0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, 0, 0, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 0, 0, 0, 1'b0);

        // backpressure: new operands held through DONE, accepted right after release
        do_op(8'h3C, 8'h4D, 1'b1, 5, 1, 0, 1'b0);
        do_op(nxt_a, nxt_b, nxt_bin, 0, 0, 0, 1'b0);

        // reset mid-RUN aborts the operation
        A = 8'h77; B = 8'h12; Bin = 1'b0; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0; IN_VALID = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1; IN_VALID = 1'b0;
        check("abort_valid", OUT_VALID, 0);
        check("abort_d", D, 0);
        check("abort_ready", IN_READY, 1);
        repeat (NIBBLES + 1) begin
            @(negedge CLK);
            check("abort_stays_idle", OUT_VALID, 0);
        end
        do_op(8'h9C, 8'h3E, 1'b0, 0, 0, 0, 1'b0);

        do_op(8'h80, 8'h01, 1'b0, 0, 0, 1, 1'b1);
        do_op(8'h7F, 8'hFF, 1'b0, 0, 0, 1, 1'b1);
        do_op(8'h05, 8'h03, 1'b0, 0, 0, 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic vx;
            logic [WIDTH-1:0] dm;
            ra = $urandom; rb = $urandom; rbin = 1'($urandom);
            dm = ra - rb - WIDTH'(rbin);
            vx = (ra[WIDTH-1] != rb[WIDTH-1]) && (dm[WIDTH-1] != ra[WIDTH-1]);
            do_op(ra, rb, rbin, $urandom_range(0, 3), 0, 1, vx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
